// File: rtl/smc_fpu_arbiter.sv
// Round-robin arbiter sharing one smc float adder and one multiplier among NREQ requesters.
// Optional WAIT timeout abort is compiled in with `define SMC_FPU_ARB_TIMEOUT_EN.
module smc_fpu_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_op,
  input  logic [32*NREQ-1:0]   i_x,
  input  logic [32*NREQ-1:0]   i_y,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_rsp_valid,
  output logic [31:0]          o_z,
  output logic                 o_err,
  output logic                 o_busy,
  output logic [31:0]          o_fpu_x,
  output logic [31:0]          o_fpu_y,
  output logic                 o_add_srdyi,
  input  logic [31:0]          i_add_z,
  input  logic                 i_add_srdyo,
  output logic                 o_mul_srdyi,
  input  logic [31:0]          i_mul_z,
  input  logic                 i_mul_srdyo
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("smc_fpu_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            op_q, op_d;
  logic [31:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic            done_q, done_d;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand_idx;
  int unsigned     cand;
  logic            sel_srdyo;
  logic [31:0]     sel_z;

`ifdef SMC_FPU_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // First requesting index at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand     = (32'(ptr_q) + i) % NREQ;
      cand_idx = IW'(cand);
      if (!found && i_req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign sel_srdyo = op_q ? i_mul_srdyo : i_add_srdyo;
  assign sel_z     = op_q ? i_mul_z     : i_add_z;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    done_d  = done_q;
`ifdef SMC_FPU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = win;
          op_d    = i_op[win];
          x_d     = i_x[32*win +: 32];
          y_d     = i_y[32*win +: 32];
          ptr_d   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
          done_d  = 1'b0;
          state_d = StIssue;
`ifdef SMC_FPU_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StIssue: begin
        // A zero-latency unit answers in the same cycle as srdyi.
        if (sel_srdyo) begin
          z_d    = sel_z;
          done_d = 1'b1;
        end
        state_d = StWait;
`ifdef SMC_FPU_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      StWait: begin
        if (done_q) begin
          state_d = StResp;
        end else if (sel_srdyo) begin
          z_d    = sel_z;
          done_d = 1'b1;
        end else begin
`ifdef SMC_FPU_ARB_TIMEOUT_EN
          if (32'(cnt_q) == TIMEOUT_CYC - 1) begin
            z_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      op_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

`ifdef SMC_FPU_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign o_err = (state_q == StResp) && err_q;
`else
  assign o_err = 1'b0;
`endif

  always_comb begin
    o_gnt       = '0;
    o_rsp_valid = '0;
    if (state_q == StIssue) o_gnt[idx_q] = 1'b1;
    if (state_q == StResp) o_rsp_valid[idx_q] = 1'b1;
  end

  assign o_add_srdyi = (state_q == StIssue) && !op_q;
  assign o_mul_srdyi = (state_q == StIssue) && op_q;
  assign o_busy      = (state_q != StIdle);
  assign o_fpu_x     = x_q;
  assign o_fpu_y     = y_q;
  assign o_z         = z_q;

endmodule
